// File: rtl/life_board_loader.sv
// Writer-side loader for the 8x8 life array.
// Collects eight row bytes over a valid/ready stream, remaps them into four
// 4x4 tiles and writes one tile per cycle. Also produces the periodic
// generation-advance strobe while running and idle.
// Ports:
//   clk, reset (async, active-low)
//   in_data/in_valid/in_ready : board row byte stream (bit c = column c)
//   run                       : level, enables free-running step generation
//   vali/vali_selector        : tile word and tile index (0=NW 1=SW 2=NE 3=SE)
//   write_enb                 : one-cycle tile write strobe
//   step                      : one-cycle generation-advance strobe
//   load_done                 : one-cycle pulse after the fourth tile write
//   busy                      : load partially collected or being written
module life_board_loader #(
  parameter int unsigned STEP_DIV = 25_000_000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        run,
  output logic [15:0] vali,
  output logic [1:0]  vali_selector,
  output logic        write_enb,
  output logic        step,
  output logic        load_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_COLLECT, S_W0, S_W1, S_W2, S_W3, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        row_q, row_d;
  logic [7:0][7:0]   board_q, board_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [15:0]       vali_d;
  logic [1:0]        sel_d;
  logic              we_d, step_d, done_d;
  logic              accept;

  // Gather one tile: tile index = {col[2], row[2]}, word bit = 4*col[1:0] + row[1:0].
  function automatic logic [15:0] tile_word(input logic [7:0][7:0] b, input logic [1:0] t);
    logic [15:0] w;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w[4'(4 * c + r)] = b[{t[0], 2'(r)}][{t[1], 2'(c)}];
      end
    end
    return w;
  endfunction

  // Handshake and occupancy are combinational views of the registered state.
  assign in_ready = reset && (state_q == S_COLLECT);
  assign busy     = (row_q != 3'd0) || (state_q != S_COLLECT);
  assign accept   = in_valid && in_ready;

  // Next-state and next-output logic; outputs are registered from the *_d values.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    board_d = board_q;
    div_d   = div_q;
    vali_d  = vali;
    sel_d   = vali_selector;
    we_d    = 1'b0;
    step_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_COLLECT: begin
        if (accept) begin
          board_d[row_q] = in_data;
          row_d          = row_q + 3'd1;
          if (row_q == 3'd7) begin
            // Tile 0 must include the byte accepted this cycle.
            state_d = S_W0;
            we_d    = 1'b1;
            sel_d   = 2'd0;
            vali_d  = tile_word(board_d, 2'd0);
          end
        end
      end
      S_W0: begin
        state_d = S_W1;
        we_d    = 1'b1;
        sel_d   = 2'd1;
        vali_d  = tile_word(board_q, 2'd1);
      end
      S_W1: begin
        state_d = S_W2;
        we_d    = 1'b1;
        sel_d   = 2'd2;
        vali_d  = tile_word(board_q, 2'd2);
      end
      S_W2: begin
        state_d = S_W3;
        we_d    = 1'b1;
        sel_d   = 2'd3;
        vali_d  = tile_word(board_q, 2'd3);
      end
      S_W3: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_COLLECT;
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase

    // A byte accepted on an expiry cycle starts a load, so that step is dropped.
    if (run && !busy && !accept) begin
      if (div_q == CNT_W'(STEP_DIV - 1)) begin
        step_d = 1'b1;
        div_d  = '0;
      end else begin
        div_d = div_q + CNT_W'(1);
      end
    end else begin
      div_d = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_COLLECT;
      row_q         <= 3'd0;
      board_q       <= '0;
      div_q         <= '0;
      vali          <= 16'd0;
      vali_selector <= 2'd0;
      write_enb     <= 1'b0;
      step          <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      board_q       <= board_d;
      div_q         <= div_d;
      vali          <= vali_d;
      vali_selector <= sel_d;
      write_enb     <= we_d;
      step          <= step_d;
      load_done     <= done_d;
    end
  end

endmodule
